// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared definitions for the FIFO write-port arbiter:
//   - arb_state_e    : arbiter FSM state encoding (IDLE / LOCKED)
//   - BEAT_CNT_WIDTH : width of the per-burst beat counter
//   - id_width()     : grant index width for a given requester count
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned BEAT_CNT_WIDTH = 8;

    // log2 of the requester count, never narrower than one bit
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Requester-side and FIFO-side handshake bundle of the write-port arbiter.
//   req_valid  : per-requester beat valid
//   req_last   : per-requester end-of-burst marker (qualified by req_valid)
//   req_data   : flattened beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : per-requester accept, one-hot or zero
//   fifo_full  : full flag from the FIFO
//   fifo_wr_en : FIFO write enable
//   fifo_din   : FIFO write data
// Modports: slave = arbiter view, master = requesters + FIFO view.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din
    );

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational rotating-priority search: returns the first asserted bit of
// req starting at rr_ptr and wrapping from NUM_REQ-1 back to 0.
//   req    : request vector
//   rr_ptr : highest-priority index this cycle (must be < NUM_REQ)
//   found  : at least one request is asserted
//   index  : winning index (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] index
);

    // Walk the offsets from farthest to nearest so the nearest hit wins
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int pos_raw;
            int pos;
            pos_raw = int'(rr_ptr) + k;
            pos     = (pos_raw >= NUM_REQ) ? (pos_raw - NUM_REQ) : pos_raw;
            index   = req[pos] ? ID_WIDTH'(pos) : index;
            found   = found | req[pos];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one async FIFO write port between NUM_REQ
// requesters. A grantee holds the port for a whole burst (until req_last)
// but is cut off after MAX_BURST beats, which sets the sticky err_overlong.
// The beat path (req_ready, fifo_wr_en, fifo_din) is combinational so a
// beat can be written in the same cycle it is presented.
//   clk          : FIFO write clock
//   rst          : synchronous active-high reset
//   bus          : requester / FIFO handshake bundle (slave modport)
//   grant_id     : current or most recent grantee
//   busy         : high while a burst holds the port
//   err_overlong : sticky, a burst was forcibly truncated
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    fifo_wr_arbiter_if.slave    bus,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                busy,
    output logic                err_overlong
);

    localparam logic [BEAT_CNT_WIDTH-1:0] MAX_BURST_C = BEAT_CNT_WIDTH'(MAX_BURST);
    localparam logic [ID_WIDTH-1:0]       LAST_ID_C   = ID_WIDTH'(NUM_REQ - 1);

    arb_state_e                state_r;
    logic [ID_WIDTH-1:0]       rr_ptr_r;
    logic [ID_WIDTH-1:0]       grant_id_r;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_r;
    logic                      busy_r;
    logic                      err_overlong_r;

    logic                      cand_found_s;
    logic [ID_WIDTH-1:0]       cand_idx_s;
    logic [ID_WIDTH-1:0]       sel_idx_s;
    logic [ID_WIDTH-1:0]       next_ptr_s;
    logic                      sel_valid_s;
    logic                      sel_last_s;
    logic                      xfer_s;
    logic                      beat_limit_s;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr_r),
        .found  (cand_found_s),
        .index  (cand_idx_s)
    );

    // Select the requester that owns the port this cycle and qualify the beat
    always_comb begin
        if (state_r == ARB_LOCKED) begin
            sel_idx_s   = grant_id_r;
            sel_valid_s = bus.req_valid[grant_id_r];
        end else begin
            sel_idx_s   = cand_idx_s;
            sel_valid_s = cand_found_s;
        end
        sel_last_s   = bus.req_last[sel_idx_s];
        // rst gates the beat so an abandoned burst never reaches the FIFO
        xfer_s       = sel_valid_s & ~bus.fifo_full & ~rst;
        next_ptr_s   = (sel_idx_s == LAST_ID_C) ? '0 : (sel_idx_s + ID_WIDTH'(1));
        beat_limit_s = ((beat_cnt_r + BEAT_CNT_WIDTH'(1)) == MAX_BURST_C);
    end

    // Drive the FIFO write port and the single accepting ready
    always_comb begin
        bus.req_ready  = '0;
        bus.fifo_wr_en = xfer_s;
        bus.fifo_din   = '0;
        if (xfer_s) begin
            bus.req_ready[sel_idx_s] = 1'b1;
            bus.fifo_din             = bus.req_data[sel_idx_s*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            bus.req_ready = '0;
        end
    end

    // Arbitration FSM, beat counter and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ARB_IDLE;
            rr_ptr_r       <= '0;
            beat_cnt_r     <= '0;
            grant_id_r     <= '0;
            busy_r         <= 1'b0;
            err_overlong_r <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (xfer_s) begin
                        grant_id_r <= sel_idx_s;
                        if (sel_last_s) begin
                            rr_ptr_r <= next_ptr_s;
                        end else begin
                            state_r    <= ARB_LOCKED;
                            beat_cnt_r <= BEAT_CNT_WIDTH'(1);
                            busy_r     <= 1'b1;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (xfer_s) begin
                        if (sel_last_s || beat_limit_s) begin
                            state_r    <= ARB_IDLE;
                            rr_ptr_r   <= next_ptr_s;
                            beat_cnt_r <= '0;
                            busy_r     <= 1'b0;
                            if (!sel_last_s) begin
                                err_overlong_r <= 1'b1;
                            end
                        end else begin
                            beat_cnt_r <= beat_cnt_r + BEAT_CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= ARB_IDLE;
                    beat_cnt_r <= '0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id     = grant_id_r;
    assign busy         = busy_r;
    assign err_overlong = err_overlong_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Each requester owns a queue of pending beats. Every cycle the stimulus
// process presents queue heads, runs a reference model of the arbitration
// rules and pushes the expected beat / status into scoreboard queues; a
// negedge monitor pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          err_overlong;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .ID_WIDTH   (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_overlong (err_overlong)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
    } beat_t;

    typedef struct {
        int wr;
        int gid;
        int busy;
        int err;
    } stat_t;

    beat_t      exp_q[$];
    stat_t      stat_q[$];
    logic [8:0] rq [NR][$];     // {last, data} per pending beat

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner < 0 means no burst holds the port
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_gid   = 0;
    int m_err   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [7:0] data, input bit last);
        rq[i].push_back({last, data});
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NR; i++) s += rq[i].size();
        return s;
    endfunction

    // One clock cycle: present inputs, predict outcome, enqueue expectations
    task automatic step(input bit rst_v, input bit full_v, input logic [NR-1:0] allow);
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*DW-1:0] d;
        int               g;
        bit               last;
        stat_t            st;
        beat_t            b;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0 && allow[i]) begin
                v[i]          = 1'b1;
                l[i]          = rq[i][0][8];
                d[i*DW +: DW] = rq[i][0][7:0];
            end else begin
                v[i]          = 1'b0;
                l[i]          = 1'($urandom_range(0, 1));
                d[i*DW +: DW] = 8'($urandom);
            end
        end
        rst           = rst_v;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.fifo_full = full_v;

        st.wr   = 0;
        st.gid  = m_gid;
        st.busy = (m_owner >= 0) ? 1 : 0;
        st.err  = m_err;
        if (rst_v) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_gid = 0; m_err = 0;
        end else begin
            g = -1;
            if (m_owner >= 0) begin
                if (v[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < NR; k++)
                    if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
            if (g >= 0 && !full_v) begin
                st.wr  = 1;
                b.idx  = g;
                b.data = int'(rq[g][0][7:0]);
                last   = rq[g][0][8];
                exp_q.push_back(b);
                void'(rq[g].pop_front());
                m_gid = g;
                if (m_owner < 0) begin
                    if (last) m_ptr = (g + 1) % NR;
                    else begin m_owner = g; m_cnt = 1; end
                end else begin
                    m_cnt++;
                    if (last || m_cnt == MB) begin
                        if (!last) m_err = 1;
                        m_owner = -1;
                        m_ptr   = (g + 1) % NR;
                        m_cnt   = 0;
                    end
                end
            end
        end
        stat_q.push_back(st);
    endtask

    // Monitor: compare DUT outputs with the scoreboard away from the clock edge
    always @(negedge clk) begin
        stat_t st;
        beat_t b;
        if (stat_q.size() > 0) begin
            st = stat_q.pop_front();
            check("wr_en", 32'(bus.fifo_wr_en), st.wr);
            check("grant_id", 32'(grant_id), st.gid);
            check("busy", 32'(busy), st.busy);
            check("err_overlong", 32'(err_overlong), st.err);
            if (bus.fifo_wr_en === 1'b1) begin
                check("beat_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check("fifo_din", 32'(bus.fifo_din), b.data);
                    check("req_ready", 32'(bus.req_ready), 32'(1) << b.idx);
                end
            end else begin
                check("req_ready_idle", 32'(bus.req_ready), 0);
                if (rst) check("din_in_reset", 32'(bus.fifo_din), 0);
            end
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b1111);

        // Round-robin rotation with single-beat traffic
        for (int i = 0; i < NR; i++) begin
            load(i, 8'(8'h10 + i), 1'b1);
            load(i, 8'(8'h20 + i), 1'b1);
        end
        repeat (8) step(1'b0, 1'b0, 4'b1111);

        // Burst lock: req1 A1..A3 while req2 waits
        load(1, 8'hA1, 1'b0); load(1, 8'hA2, 1'b0); load(1, 8'hA3, 1'b1);
        load(2, 8'hB1, 1'b1); load(2, 8'hB2, 1'b1);
        repeat (6) step(1'b0, 1'b0, 4'b0110);

        // Backpressure mid-burst of req0
        load(0, 8'hC0, 1'b0); load(0, 8'hC1, 1'b0); load(0, 8'hC2, 1'b1);
        step(1'b0, 1'b0, 4'b0001);
        repeat (5) step(1'b0, 1'b1, 4'b0001);
        repeat (4) step(1'b0, 1'b0, 4'b0001);

        // Overlong burst from req3, req0 waiting
        for (int i = 0; i < 7; i++) load(3, 8'(8'hD0 + i), i == 6);
        load(0, 8'hE0, 1'b1);
        repeat (12) step(1'b0, 1'b0, 4'b1001);

        // Reset mid-burst of req2, then grant restarts from requester 0
        for (int i = 0; i < 4; i++) load(2, 8'(8'h60 + i), i == 3);
        repeat (2) step(1'b0, 1'b0, 4'b0100);
        step(1'b1, 1'b0, 4'b0100);
        load(1, 8'h71, 1'b1);
        repeat (6) step(1'b0, 1'b0, 4'b0110);

        // Sparse: only req3, single beats back to back
        for (int i = 0; i < 5; i++) load(3, 8'(8'h80 + i), 1'b1);
        repeat (6) step(1'b0, 1'b0, 4'b1000);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 6));
                    for (int j = 0; j < len; j++) load(i, 8'($urandom), j == len - 1);
                end
            end
            step(1'b0, $urandom_range(0, 4) == 0, NR'($urandom));
        end

        // Drain remaining beats, bounded
        for (int c = 0; c < 400 && pending() > 0; c++) step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        #1;
        check("leftover_expected_beats", 32'(exp_q.size()), 0);
        check("undrained_requests", 32'(pending()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the write port of one async_fifo between NUM_REQ requesters (e.g. CPU MMIO store path and a DMA/boot loader feeding the UART TX FIFO).
- Runs in the FIFO write-clock domain and drives the FIFO's wr_en/din directly.
- Supports multi-beat bursts: a grantee keeps the port until it presents a beat with req_last=1.
- Bursts longer than MAX_BURST beats are forcibly released and flagged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO data width.
- MAX_BURST, 16, maximum beats per grant before forced release (2..255).
- ID_WIDTH, `log2(NUM_REQ), grant index width.

Ports:
- clk  in  1  write-side clock, same clock as the FIFO wr_clk.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; beat i is accepted when req_valid[i] & req_ready[i].
- fifo_full  in  1  full flag from the FIFO.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DATA_WIDTH  FIFO write data.
- grant_id  out  ID_WIDTH  index of the current or most recent grantee.
- busy  out  1  high while in LOCKED.
- err_overlong  out  1  sticky flag: a burst was forcibly truncated.

Behaviour:
- Clocking: single clk; all state updates on posedge clk; rst is synchronous and active-high.
- Reset state:
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, err_overlong=0.
  - req_ready=0, fifo_wr_en=0 and fifo_din=0 while rst is high.
- State IDLE, candidate selection:
  - Candidate = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Selection is combinational; there is no grant latency.
- Transfer rule (any state): xfer = req_valid[g] & ~fifo_full, where g is the candidate (IDLE) or the held grantee (LOCKED).
  - On xfer: req_ready[g]=1, fifo_wr_en=1, fifo_din=req_data[g].
  - Otherwise all req_ready=0 and fifo_wr_en=0.
  - fifo_din is combinational with zero latency.
- While fifo_full=1:
  - No beat is accepted and state does not change.
  - In IDLE, no grant is recorded (grant_id unchanged).
- IDLE, on xfer:
  - grant_id<=g.
  - If req_last[g]=1: stay IDLE, rr_ptr<=(g+1) mod NUM_REQ.
  - Else: state<=LOCKED, beat_cnt<=1.
- LOCKED:
  - Only grant_id is served; other requesters see req_ready=0.
  - If grantee deasserts req_valid: stay LOCKED with no timeout.
  - On xfer, beat_cnt<=beat_cnt+1.
  - Release when req_last=1 or beat_cnt+1==MAX_BURST: state<=IDLE, rr_ptr<=(grant_id+1) mod NUM_REQ, beat_cnt<=0.
  - If release is due to MAX_BURST and req_last=0: err_overlong<=1, sticky until rst.
- MAX_BURST counting: beat_cnt is 8 bits and counts beats accepted in the current burst, including the first.
- Wrap-around: rr_ptr search wraps from NUM_REQ-1 to 0.
- Fairness: with all requesters continuously valid and single-beat traffic, grants rotate 0,1,2,3,0,...
- Simultaneous events:
  - A new requester asserting in the same cycle as a release does not preempt; the next cycle's IDLE search uses the updated rr_ptr.
  - In IDLE, a single-beat transfer and another request in the same cycle: one beat per cycle maximum.
- Reset mid-burst: the burst is abandoned with no FIFO write in the reset cycle; the next grant starts from requester 0.
- busy = (state==LOCKED).

Decomposition:
- Shared header util.vh: `log2 macro and a localparam pair for state encodings (ARB_IDLE=1'b0, ARB_LOCKED=1'b1).
- One natural sub-module, rr_priority_picker: combinational. Inputs: req vector and rr_ptr. Outputs: found and index.
- The FSM, beat counter and data mux stay in fifo_wr_arbiter.

Test Plan:
- Round-robin rotation: NUM_REQ=4, all valid, all req_last=1, fifo_full=0 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3; fifo_din matches each requester's data every cycle.
- Burst lock: req1 sends 3 beats 0xA1,0xA2,0xA3 (last on the 3rd) while req2 is valid throughout -> FIFO receives A1,A2,A3 consecutively; req2 is granted on the 4th cycle; busy is high for cycles 2-3.
- Backpressure: fifo_full=1 for 5 cycles mid-burst of req0 -> fifo_wr_en=0, all req_ready=0, state LOCKED, beat_cnt frozen; after release, the burst resumes with no lost or duplicated beat.
- Overlong: MAX_BURST=4, req3 streams 6 beats with last=0 -> 4 beats written; err_overlong=1 from the cycle after the 4th beat; next grant goes to requester 0 if valid; err_overlong stays 1.
- Reset mid-burst: rst pulsed for 1 cycle after 2 beats of req2 -> fifo_wr_en=0 that cycle, state IDLE, err_overlong=0; next grant goes to the lowest valid index starting at 0.
- Sparse requests: only req3 valid, single beats -> granted every cycle; rr_ptr wraps to 0 after each grant; no idle cycles inserted.
